// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: immediate extender feeding a DEPTH-entry output FIFO.
// Each accepted request is extended combinationally and pushed in the
// same cycle; the FIFO head is presented on out_imm/out_err.
module imm_ext_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] pc_plus4,
    input  logic [2:0]        mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_imm,
    output logic              out_err,
    output logic [7:0]        err_cnt
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        M_SEXT16 = 3'd0,
        M_ZEXT16 = 3'd1,
        M_LUI    = 3'd2,
        M_BRANCH = 3'd3,
        M_SEXT26 = 3'd4,
        M_JUMP   = 3'd5
    } mode_e;

    logic [15:0]       imm16;
    logic [25:0]       imm26;
    logic [DATA_W-1:0] calc_imm;
    logic              calc_err;

    logic [DATA_W:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        err_cnt_q;
    logic              rdy_q;
    logic              full;
    logic              push;
    logic              pop;
    logic [DATA_W:0]   head;
    logic              unused_bits;

    assign imm16 = instr[15:0];
    assign imm26 = instr[25:0];

    // Only the immediate fields and the PC region bits feed the result.
    assign unused_bits = ^{instr[31:26], pc_plus4[27:0]};

    // Immediate extension; wider-than-32 results start from a sign fill
    // and then overwrite the low bits so DATA_W == 32 needs no special case.
    always_comb begin
        calc_imm = '0;
        calc_err = 1'b0;
        case (mode)
            M_SEXT16: begin
                calc_imm        = {DATA_W{imm16[15]}};
                calc_imm[15:0]  = imm16;
            end
            M_ZEXT16: begin
                calc_imm[15:0]  = imm16;
            end
            M_LUI: begin
                calc_imm        = {DATA_W{imm16[15]}};
                calc_imm[31:0]  = {imm16, 16'h0000};
            end
            M_BRANCH: begin
                calc_imm        = {DATA_W{imm16[15]}};
                calc_imm[17:0]  = {imm16, 2'b00};
            end
            M_SEXT26: begin
                calc_imm        = {DATA_W{imm26[25]}};
                calc_imm[25:0]  = imm26;
            end
            M_JUMP: begin
                calc_imm        = pc_plus4;
                calc_imm[27:0]  = {imm26, 2'b00};
            end
            default: begin
                calc_imm = '0;
                calc_err = 1'b1;
            end
        endcase
    end

    assign full      = (cnt_q == CNT_W'(DEPTH));
    assign out_valid = (cnt_q != '0);
    assign pop       = out_valid & out_ready;
    assign in_ready  = rdy_q & (~full | pop);
    assign push      = in_valid & in_ready;

    assign head      = mem_q[rd_ptr_q];
    assign out_imm   = out_valid ? head[DATA_W-1:0] : '0;
    assign out_err   = out_valid ? head[DATA_W] : 1'b0;
    assign err_cnt   = err_cnt_q;

    // Next pointer and occupancy values; pointers wrap at DEPTH-1.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop && !push) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Control state: pointers, occupancy, ready flag and saturating error count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            err_cnt_q <= '0;
            rdy_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            rdy_q    <= 1'b1;
            if (push && calc_err && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'd1;
            end
        end
    end

    // FIFO storage; contents are only observable through valid entries.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {calc_err, calc_imm};
        end
    end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// tb_imm_ext_pipe: directed and random stimulus against a queue-based
// reference model of the immediate extender and its output FIFO.
module tb_imm_ext_pipe;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 2;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instr;
    logic [DATA_W-1:0] pc_plus4;
    logic [2:0]        mode;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_imm;
    logic              out_err;
    logic [7:0]        err_cnt;

    imm_ext_pipe #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .pc_plus4  (pc_plus4),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_imm   (out_imm),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [32:0] q[$];
    int          m_errs = 0;
    bit          m_rdy  = 1'b0;

    function automatic logic [32:0] ref_calc(input logic [31:0] w,
                                             input logic [31:0] pc,
                                             input logic [2:0]  md);
        longint s16;
        longint s26;
        longint r;
        s16 = w[15] ? longint'(w[15:0]) - 65536 : longint'(w[15:0]);
        s26 = w[25] ? longint'(w[25:0]) - 67108864 : longint'(w[25:0]);
        case (md)
            3'd0: r = s16;
            3'd1: r = longint'(w[15:0]);
            3'd2: r = s16 * 65536;
            3'd3: r = s16 * 4;
            3'd4: r = s26;
            3'd5: r = (longint'(pc) / 268435456) * 268435456 + longint'(w[25:0]) * 4;
            default: return {1'b1, 32'h0};
        endcase
        return {1'b0, r[31:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [32:0] h;
        bit          erdy;
        h    = (q.size() > 0) ? q[0] : 33'h0;
        erdy = m_rdy && ((q.size() < DEPTH) || (out_ready && q.size() > 0));
        check("in_ready",  32'(in_ready),  32'(erdy));
        check("out_valid", 32'(out_valid), 32'(q.size() > 0));
        check("out_imm",   out_imm,        h[31:0]);
        check("out_err",   32'(out_err),   32'(h[32]));
        check("err_cnt",   32'(err_cnt),   32'((m_errs > 255) ? 255 : m_errs));
    endtask

    // One clock: drive, check against model, advance model across the edge.
    task automatic step(input logic iv, input logic [31:0] w, input logic [31:0] pc,
                        input logic [2:0] md, input logic ordy);
        bit          do_push;
        bit          do_pop;
        logic [32:0] e;
        in_valid  = iv;
        instr     = w;
        pc_plus4  = pc;
        mode      = md;
        out_ready = ordy;
        #1;
        check_model();
        do_pop  = ordy && (q.size() > 0);
        do_push = iv && m_rdy && ((q.size() < DEPTH) || do_pop);
        e       = ref_calc(w, pc, md);
        @(posedge clk);
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
            q.push_back(e);
            if (e[32]) m_errs++;
        end
        m_rdy = 1'b1;
        #1;
    endtask

    logic [31:0] a_exp;
    logic [31:0] b_exp;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        instr     = '0;
        pc_plus4  = '0;
        mode      = '0;
        out_ready = 1'b0;
        #3;
        check_model();
        check("rst_in_ready", 32'(in_ready), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // First edge after release makes the block ready
        step(1'b0, 32'h0, 32'h0, 3'd0, 1'b0);
        check("ready_after_rst", 32'(in_ready), 32'h1);

        // Sign/zero extension, LUI, BRANCH, JUMP with literal expectations
        step(1'b1, 32'h0000_8001, 32'h0, 3'd0, 1'b1);
        check("sext16", out_imm, 32'hFFFF_8001);
        step(1'b1, 32'h0000_8001, 32'h0, 3'd1, 1'b1);
        check("zext16", out_imm, 32'h0000_8001);
        step(1'b1, 32'h0000_1234, 32'h0, 3'd2, 1'b1);
        check("lui", out_imm, 32'h1234_0000);
        step(1'b1, 32'h0000_FFFF, 32'h0, 3'd3, 1'b1);
        check("branch", out_imm, 32'hFFFF_FFFC);
        step(1'b1, 32'h0000_0010, 32'hA000_0004, 3'd5, 1'b1);
        check("jump", out_imm, 32'hA000_0040);
        step(1'b0, 32'h0, 32'h0, 3'd0, 1'b1);
        check("drained", 32'(out_valid), 32'h0);

        // Backpressure: A, B fill the FIFO, C stalls
        a_exp = 32'h0000_0111;
        b_exp = 32'h0000_0222;
        step(1'b1, a_exp, 32'h0, 3'd1, 1'b0);
        step(1'b1, b_exp, 32'h0, 3'd1, 1'b0);
        step(1'b1, 32'h0000_0333, 32'h0, 3'd1, 1'b0);
        check("stall_ready", 32'(in_ready), 32'h0);
        check("stall_head", out_imm, a_exp);
        step(1'b1, 32'h0000_0333, 32'h0, 3'd1, 1'b1);
        check("order_b", out_imm, b_exp);
        step(1'b0, 32'h0, 32'h0, 3'd0, 1'b1);
        check("order_c", out_imm, 32'h0000_0333);
        step(1'b0, 32'h0, 32'h0, 3'd0, 1'b1);

        // Full FIFO with push and pop every cycle
        step(1'b1, $urandom, $urandom, 3'd0, 1'b0);
        step(1'b1, $urandom, $urandom, 3'd4, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, $urandom, $urandom, 3'($urandom_range(0, 5)), 1'b1);
            check("full_occupancy", 32'(q.size()), 32'(DEPTH));
        end
        step(1'b0, 32'h0, 32'h0, 3'd0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 3'd0, 1'b1);

        // Illegal mode saturation
        for (int i = 0; i < 300; i++) begin
            step(1'b1, $urandom, $urandom, 3'd7, 1'b1);
        end
        check("err_sat", 32'(err_cnt), 32'd255);
        step(1'b0, 32'h0, 32'h0, 3'd0, 1'b1);

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom), $urandom, $urandom, 3'($urandom), 1'($urandom));
        end

        // Reset mid-operation with two entries buffered
        step(1'b0, 32'h0, 32'h0, 3'd0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 3'd0, 1'b1);
        step(1'b1, 32'h0000_0AAA, 32'h0, 3'd1, 1'b0);
        step(1'b1, 32'h0000_0BBB, 32'h0, 3'd1, 1'b0);
        check("pre_rst_valid", 32'(out_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        q.delete();
        m_errs = 0;
        m_rdy  = 1'b0;
        #1;
        check_model();
        check("rst_valid", 32'(out_valid), 32'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 32'h0, 32'h0, 3'd0, 1'b1);
            check("no_stale", 32'(out_valid), 32'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imm_ext_pipe.md
IMM_EXT_PIPE -- requirements
Module: imm_ext_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the output data width; legal values are 32 or more.
REQ-002 The block SHALL have parameter DEPTH, default 2, giving the output buffer entries; legal values are 2 or more.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 Port list, one port per line (name, direction, width, meaning):
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  request present
- in_ready  output  1  block can accept a request
- instr  input  32  instruction word; imm16 = instr[15:0], imm26 = instr[25:0]
- pc_plus4  input  DATA_W  PC+4 of the instruction
- mode  input  3  extension mode (see REQ-008)
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts the result
- out_imm  output  DATA_W  extended immediate
- out_err  output  1  result came from an illegal mode
- err_cnt  output  8  saturating count of illegal-mode requests accepted

Function
REQ-005 An input transfer SHALL occur when in_valid=1 and in_ready=1 on a rising edge.
REQ-006 An output transfer SHALL occur when out_valid=1 and out_ready=1 on a rising edge.
REQ-007 Each accepted request SHALL be computed combinationally and written into a FIFO of DEPTH entries in the same cycle.
- Latency: a result is visible on out_* in the cycle after acceptance, when the FIFO was empty.
REQ-008 The mode encodings SHALL be:
- 0 SEXT16: imm16 sign-extended to DATA_W.
- 1 ZEXT16: imm16 zero-extended to DATA_W.
- 2 LUI: {imm16, 16'b0}; bits above 31 take the sign of imm16[15].
- 3 BRANCH: imm16 sign-extended, shifted left by 2.
- 4 SEXT26: imm26 sign-extended to DATA_W.
- 5 JUMP: {pc_plus4[DATA_W-1:28], imm26, 2'b00}.
REQ-009 For modes 6 and 7:
- out_imm SHALL be 0 and out_err SHALL be 1 for that entry.
- err_cnt SHALL increment on acceptance and saturate at 255.
REQ-010 in_ready SHALL equal (FIFO not full) OR (out_ready=1 AND out_valid=1).
- An accept into a full FIFO is legal only while a pop happens in the same cycle.
REQ-011 out_valid SHALL equal (FIFO not empty).
- out_imm and out_err SHALL present the oldest entry.
- Both SHALL stay stable while out_valid=1 and out_ready=0.
REQ-012 A simultaneous push and pop SHALL leave the occupancy unchanged and preserve order.
- This includes the full case and the case of exactly one entry.
REQ-013 The read and write pointers SHALL wrap from DEPTH-1 to 0.
- An occupancy counter of width clog2(DEPTH+1) SHALL distinguish full from empty.
REQ-014 Results SHALL leave in strict acceptance order, with none lost or duplicated.
REQ-015 If the FIFO is empty, out_ready SHALL have no effect.
REQ-016 If in_ready=0, in_valid SHALL have no effect.

Reset
REQ-017 While rst_n=0, asynchronously and regardless of the clock:
- The FIFO SHALL empty, with pointers and occupancy at 0.
- out_valid SHALL be 0 and in_ready SHALL be 0.
- out_imm SHALL be 0, out_err SHALL be 0 and err_cnt SHALL be 0.
REQ-018 After rst_n rises, in_ready SHALL be 1 from the first clock edge.
REQ-019 A reset asserted mid-operation SHALL discard all buffered results; nothing is emitted afterwards.

Verification
REQ-020 Sign extension, out_ready=1: SEXT16 with instr[15:0]=16'h8001 -> out_imm=32'hFFFF8001 one cycle later; ZEXT16 with the same instr -> 32'h00008001.
REQ-021 LUI, BRANCH and JUMP:
- LUI with imm16=16'h1234 -> 32'h12340000.
- BRANCH with imm16=16'hFFFF -> 32'hFFFFFFFC.
- JUMP with pc_plus4=32'hA0000004 and imm26=26'h0000010 -> 32'hA0000040.
REQ-022 Backpressure, DEPTH=2:
- Hold out_ready=0 and push 3 requests; the third stalls with in_ready=0 and out_imm holds the first result.
- Then raise out_ready; results appear in order A, B, C, one per cycle.
REQ-023 Full with simultaneous push and pop: with the FIFO full and out_ready=1, in_ready=1, the occupancy stays 2 and order is preserved over 10 back-to-back transfers.
REQ-024 Illegal mode: 300 accepted mode=7 requests -> every result has out_imm=0 and out_err=1, and err_cnt=255.
REQ-025 Reset mid-operation: assert rst_n=0 between clock edges with 2 entries buffered -> out_valid=0 immediately, and no stale result appears after release.
